// File: rtl/instq_pkg.sv
// Shared instruction-queue definitions: field widths and the packed entry
// carried from fetch through the dispatch buffer to dispatch.
package instq_pkg;

    localparam int OPCODE_W = 12;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int ADDR_W   = 26;
    localparam int PC_W     = 32;

    // One decoded instruction as stored in the buffer (106 bits).
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [IMM_W-1:0]    imm;
        logic [ADDR_W-1:0]   addr;
        logic [PC_W-1:0]     pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/dispatch_buffer.sv
// Show-ahead instruction buffer between fetch and dispatch. Occupancy is
// tracked by an explicit counter so full/empty never rely on pointer equality.
module dispatch_buffer
    import instq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [OPCODE_W-1:0]        in_opcode,
    input  logic [REG_W-1:0]           in_rs,
    input  logic [REG_W-1:0]           in_rt,
    input  logic [REG_W-1:0]           in_rd,
    input  logic [REG_W-1:0]           in_shamt,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       in_ready,
    output logic                       almost_full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPCODE_W-1:0]        out_opcode,
    output logic [REG_W-1:0]           out_rs,
    output logic [REG_W-1:0]           out_rt,
    output logic [REG_W-1:0]           out_rd,
    output logic [REG_W-1:0]           out_shamt,
    output logic [IMM_W-1:0]           out_imm,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    // Set by the first push after reset; until then the array holds
    // undefined data, so the head fields are forced to zero.
    logic               r_fresh;

    entry_t             w_in_entry;
    entry_t             w_head_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // Assemble the incoming fields into one packed entry.
    always_comb begin
        w_in_entry        = '0;
        w_in_entry.opcode = in_opcode;
        w_in_entry.rs     = in_rs;
        w_in_entry.rt     = in_rt;
        w_in_entry.rd     = in_rd;
        w_in_entry.shamt  = in_shamt;
        w_in_entry.imm    = in_imm;
        w_in_entry.addr   = in_addr;
        w_in_entry.pc     = in_pc;
    end

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    // Storage write at the tail; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst && w_push && !flush) begin
            r_mem[r_tail] <= w_in_entry;
        end
    end

    // Pointer, occupancy and status update; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_fresh    <= 1'b0;
        end else begin
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail  <= r_tail + PTR_W'(1);
                    r_fresh <= 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Show-ahead read of the head slot, zeroed until the first push.
    always_comb begin
        w_head_entry = r_fresh ? r_mem[r_head] : '0;
    end

    assign out_opcode  = w_head_entry.opcode;
    assign out_rs      = w_head_entry.rs;
    assign out_rt      = w_head_entry.rt;
    assign out_rd      = w_head_entry.rd;
    assign out_shamt   = w_head_entry.shamt;
    assign out_imm     = w_head_entry.imm;
    assign out_addr    = w_head_entry.addr;
    assign out_pc      = w_head_entry.pc;

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign almost_full = (r_count >= CNT_W'(AF_LEVEL));
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer at DEPTH=8 with hand-computed expectations.
module tb_dispatch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_opcode = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_addr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready, almost_full, out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [25:0] out_addr;
    logic [31:0] out_pc;
    logic        flush = 1'b0;
    logic [3:0]  count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    dispatch_buffer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_addr(in_addr),
        .in_pc(in_pc), .in_ready(in_ready), .almost_full(almost_full),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_imm(out_imm), .out_addr(out_addr), .out_pc(out_pc),
        .flush(flush), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [11:0] op, input logic [4:0] rd);
        in_valid  = v;
        in_pc     = pc;
        in_opcode = op;
        in_rd     = rd;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_out_opcode", 32'(out_opcode), 0);
        step();
        rst = 1'b1;
        step();

        // Single push: visible one cycle later.
        drive(1, 32'h0, 12'h020, 5'd3);
        in_rs = 5'd1; in_rt = 5'd2; in_shamt = 5'd4; in_imm = 16'hBEEF; in_addr = 26'h123_4567;
        step();
        drive(0, 0, 0, 0);
        check("one_out_valid", 32'(out_valid), 1);
        check("one_out_opcode", 32'(out_opcode), 32'h020);
        check("one_out_rd", 32'(out_rd), 3);
        check("one_count", 32'(count), 1);
        check("one_fields", {out_rs, out_rt, out_shamt, 17'h0}, {5'd1, 5'd2, 5'd4, 17'h0});
        check("one_imm_addr", {out_imm, 16'h0}, 32'hBEEF_0000);
        check("one_addr", 32'(out_addr), 32'h123_4567);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("one_pop_count", 32'(count), 0);
        check("one_pop_valid", 32'(out_valid), 0);

        // Fill to DEPTH with no consumer.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'(i * 4), 12'(i + 1), 5'(i));
            step();
            check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
            check($sformatf("fill%0d_af", i), 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check($sformatf("fill%0d_in_ready", i), 32'(in_ready), (i + 1 == 8) ? 0 : 1);
        end
        drive(1, 32'hDEAD, 12'hFFF, 5'd31);
        step();
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_head_pc", out_pc, 0);

        // Full with push attempt and pop: only the pop happens.
        out_ready = 1'b1;
        step();
        drive(0, 0, 0, 0);
        out_ready = 1'b0;
        check("fullpop_count", 32'(count), 7);
        check("fullpop_in_ready", 32'(in_ready), 1);
        check("fullpop_head_pc", out_pc, 4);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain%0d_pc", i), out_pc, 32'(i * 4));
            step();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        check("drain_overflow_sticky", 32'(overflow), 1);

        // Push+pop at count=1: new entry becomes head.
        drive(1, 32'h55, 12'h1, 5'd1);
        step();
        drive(1, 32'h66, 12'h2, 5'd2);
        out_ready = 1'b1;
        step();
        drive(0, 0, 0, 0);
        check("c1_count", 32'(count), 1);
        check("c1_head_pc", out_pc, 32'h66);
        step();
        out_ready = 1'b0;
        check("c1_empty", 32'(count), 0);

        // Steady state at count=3 with 20 cycles of push+pop.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(100 + i), 12'h3, 5'd0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1, 32'(k), 12'h4, 5'd0);
            check($sformatf("ss%0d_pc", k), out_pc, (k < 3) ? 32'(100 + k) : 32'(k - 3));
            step();
            check($sformatf("ss%0d_count", k), 32'(count), 3);
        end
        drive(0, 0, 0, 0);
        for (int k = 17; k < 20; k++) begin
            check($sformatf("ssdrain%0d_pc", k), out_pc, 32'(k));
            step();
        end
        out_ready = 1'b0;
        check("ss_empty", 32'(count), 0);

        // Flush at count=5 with a coincident push.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(200 + i), 12'h5, 5'd0);
            step();
        end
        check("pre_flush_count", 32'(count), 5);
        drive(1, 32'd999, 12'h6, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        check("flush_count", 32'(count), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        drive(1, 32'd300, 12'h7, 5'd0);
        step();
        drive(0, 0, 0, 0);
        check("postflush_count", 32'(count), 1);
        check("postflush_pc", out_pc, 32'd300);

        // Asynchronous reset between edges at count=4.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(400 + i), 12'h8, 5'd0);
            step();
        end
        drive(0, 0, 0, 0);
        check("pre_arst_count", 32'(count), 4);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_opcode", 32'(out_opcode), 0);
        #2;
        rst = 1'b1;
        step();
        drive(1, 32'h77, 12'h9, 5'd7);
        step();
        drive(0, 0, 0, 0);
        check("after_arst_count", 32'(count), 1);
        check("after_arst_pc", out_pc, 32'h77);
        check("after_arst_opcode", 32'(out_opcode), 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; `clk` and `rst` SHALL be the first two ports.
REQ-002 Parameter: DEPTH, default 8, number of entries; SHALL be a power of two, 2..32.
REQ-003 Parameter: AF_LEVEL, default DEPTH-2, occupancy at and above which `almost_full` asserts.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous reset, active when 0.
REQ-006 Port: in_valid  in  1  decoded instruction present; driven by the fetch-stage VALID_Inst.
REQ-007 Port: in_opcode  in  12  {op[5:0], funct[5:0]}; funct is 0 for non-R-type.
REQ-008 Port: in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-009 Port: in_imm  in  16; in_addr  in  26; in_pc  in  32.
REQ-010 Port: in_ready  out  1  entry free this cycle.
REQ-011 Port: almost_full  out  1  PC-advance stall hint to fetch.
REQ-012 Port: out_valid  out  1  head entry valid.
REQ-013 Port: out_ready  in  1  dispatch consumes the head entry.
REQ-014 Port: out_opcode, out_rs, out_rt, out_rd, out_shamt, out_imm, out_addr, out_pc  out  same widths as the inputs  head entry fields.
REQ-015 Port: flush  in  1  discard all entries; driven by mispredict or exception redirect.
REQ-016 Port: count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 Port: overflow  out  1  sticky flag: a push was attempted while full.

Function
REQ-018 Push SHALL occur on the rising edge when in_valid=1 and in_ready=1; all input fields SHALL be captured as one 106-bit entry at the tail.
REQ-019 Pop SHALL occur on the rising edge when out_valid=1 and out_ready=1; the head pointer SHALL then advance.
REQ-020 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_* SHALL show the head entry combinationally (show-ahead), with zero-cycle read latency.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers. This includes count=1, where the new entry becomes head on the next cycle.
REQ-023 Push-to-visible latency SHALL be one cycle: an entry written into an empty buffer appears on out_* with out_valid=1 after the same rising edge.
REQ-024 Head and tail pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full and empty SHALL be decided from count, not from pointer equality.
REQ-025 almost_full SHALL equal (count >= AF_LEVEL).
REQ-026 in_valid=1 while count==DEPTH SHALL drop the entry, leave state unchanged and set overflow; overflow SHALL clear only on reset.
REQ-027 flush=1 SHALL set head=tail=0 and count=0 on that edge. Flush SHALL take priority over a push or pop in the same cycle, so the coincident in_valid entry is discarded.
REQ-028 When out_valid=0, out_* SHALL hold the value stored at the head slot; consumers SHALL ignore them.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for a clock edge, set head=0, tail=0, count=0, overflow=0.
REQ-030 During and after reset, out_valid=0, in_ready=1 and almost_full=0.
REQ-031 Storage array contents SHALL NOT require reset. out_* fields SHALL read 0 after reset: gate them to 0 while count==0 following reset, or reset the array.
REQ-032 Reset asserted mid-operation SHALL discard all entries. The first push after rst returns to 1 SHALL land in slot 0.

Structure
REQ-033 Field widths (OPCODE_W=12, REG_W=5, IMM_W=16, ADDR_W=26, PC_W=32) and the packed entry type SHALL live in the shared instq_pkg, which is also used by the fetch stage and dispatch.
REQ-034 Storage SHALL be a single register array of packed entries inside dispatch_buffer; no sub-module is required.

Verification
REQ-035 Reset then push one entry (opcode 0x020, rs=1, rt=2, rd=3, pc=0) -> next cycle out_valid=1, out_opcode=0x020, out_rd=3, count=1.
REQ-036 Push 8 entries with out_ready=0 (DEPTH=8) -> almost_full=1 from count=6, in_ready=0 at count=8; a 9th in_valid sets overflow=1 and count stays 8.
REQ-037 Full buffer with in_valid=1 and out_ready=1 -> pop only, count=7, and in_ready=1 on the next cycle.
REQ-038 count=3 with push and pop in the same cycle for 20 cycles, pc 0..19 -> count stays 3, outputs appear in order, pointers wrap correctly.
REQ-039 count=5, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, and the coincident entry is absent.
REQ-040 rst driven to 0 asynchronously between clock edges at count=4 -> out_valid falls immediately, count=0, overflow=0.
